// File: rtl/csi2_video_frame_gate.sv
// rtl/csi2_video_frame_gate.sv - CSI-2 video frame gate: geometry check, SOF-aligned forwarding, stats
// Forwards only frames entered at a clean SOF; any width/height violation drops until the next SOF.
module csi2_video_frame_gate #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 13,
  parameter int STAT_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic [CNT_WIDTH-1:0]    frame_width_i,
  input  logic [CNT_WIDTH-1:0]    frame_height_i,
  input  logic [DATA_WIDTH-1:0]   video_i_tdata,
  input  logic                    video_i_tvalid,
  output logic                    video_i_tready,
  input  logic                    video_i_tuser,
  input  logic                    video_i_tlast,
  output logic [DATA_WIDTH-1:0]   video_o_tdata,
  output logic                    video_o_tvalid,
  input  logic                    video_o_tready,
  output logic                    video_o_tuser,
  output logic                    video_o_tlast,
  output logic [DATA_WIDTH/8-1:0] video_o_tkeep,
  output logic [DATA_WIDTH/8-1:0] video_o_tstrb,
  output logic                    video_o_tid,
  output logic                    video_o_tdest,
  output logic                    frame_done_o,
  output logic                    frame_err_o,
  output logic [STAT_WIDTH-1:0]   frame_cnt_o,
  output logic [STAT_WIDTH-1:0]   err_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, PASS, DROP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    px_q, px_d, line_q, line_d, w_q, w_d, h_q, h_d;
  logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
  logic                    o_valid_q, o_valid_d, o_user_q, o_user_d, o_last_q, o_last_d;
  logic                    o_done_q, o_done_d, err_q, err_d;
  logic [STAT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  logic                    can_load, beat, sof, fwd, at_end, at_last_line;
  logic                    short_err, long_err, early_sof, eol_ok, frame_end;
  logic [CNT_WIDTH-1:0]    cur_w, cur_h, cur_px, cur_line;

  always_comb begin
    can_load       = !o_valid_q || video_o_tready;
    // IDLE always sinks; elsewhere acceptance waits for room in the output stage
    video_i_tready = (state_q == IDLE) || can_load;
    beat           = video_i_tvalid && video_i_tready;
    sof            = beat && video_i_tuser &&
                     ((state_q == PASS) ||
                      (enable_i && ((state_q == WAIT_SOF) || (state_q == DROP))));
    fwd            = sof || (beat && (state_q == PASS));

    // An SOF beat is judged against freshly sampled geometry as pixel 0 of line 0
    cur_w          = sof ? frame_width_i  : w_q;
    cur_h          = sof ? frame_height_i : h_q;
    cur_px         = sof ? '0 : px_q;
    cur_line       = sof ? '0 : line_q;
    at_end         = (cur_px == cur_w - CNT_WIDTH'(1));
    at_last_line   = (cur_line == cur_h - CNT_WIDTH'(1));

    early_sof      = sof && (state_q == PASS);
    short_err      = fwd && video_i_tlast && !at_end;
    long_err       = fwd && !video_i_tlast && at_end;
    eol_ok         = fwd && video_i_tlast && at_end;
    frame_end      = eol_ok && at_last_line;

    state_d = state_q;
    px_d    = px_q;
    line_d  = line_q;
    w_d     = w_q;
    h_d     = h_q;
    case (state_q)
      IDLE:     if (enable_i) state_d = WAIT_SOF;
      WAIT_SOF: if (!enable_i) state_d = IDLE;
      DROP:     if (beat && video_i_tuser && !enable_i) state_d = IDLE;
      default:  state_d = state_q;
    endcase

    if (fwd) begin
      w_d = cur_w;
      h_d = cur_h;
      if (short_err || long_err) begin
        state_d = DROP;
      end else if (frame_end) begin
        state_d = enable_i ? WAIT_SOF : IDLE;
        px_d    = '0;
        line_d  = '0;
      end else if (eol_ok) begin
        state_d = PASS;
        px_d    = '0;
        line_d  = cur_line + CNT_WIDTH'(1);
      end else begin
        state_d = PASS;
        px_d    = cur_px + CNT_WIDTH'(1);
        line_d  = cur_line;
      end
    end

    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_user_d  = o_user_q;
    o_last_d  = o_last_q;
    o_done_d  = o_done_q;
    if (fwd) begin
      o_valid_d = 1'b1;
      o_data_d  = video_i_tdata;
      o_user_d  = video_i_tuser;
      o_last_d  = video_i_tlast || long_err;
      o_done_d  = frame_end;
    end else if (video_o_tready) begin
      o_valid_d = 1'b0;
    end

    frame_done_o = o_valid_q && video_o_tready && o_done_q;
    err_d        = early_sof || short_err || long_err;

    frame_cnt_d = frame_cnt_q;
    if (frame_done_o && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + STAT_WIDTH'(1);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      px_q        <= '0;
      line_q      <= '0;
      w_q         <= '0;
      h_q         <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_user_q    <= 1'b0;
      o_last_q    <= 1'b0;
      o_done_q    <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      line_q      <= line_d;
      w_q         <= w_d;
      h_q         <= h_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_user_q    <= o_user_d;
      o_last_q    <= o_last_d;
      o_done_q    <= o_done_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign video_o_tdata  = o_data_q;
  assign video_o_tvalid = o_valid_q;
  assign video_o_tuser  = o_user_q;
  assign video_o_tlast  = o_last_q;
  assign video_o_tkeep  = '1;
  assign video_o_tstrb  = '1;
  assign video_o_tid    = 1'b0;
  assign video_o_tdest  = 1'b0;
  assign frame_err_o    = err_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_csi2_video_frame_gate.sv
// tb/tb_csi2_video_frame_gate.sv - scoreboard bench for csi2_video_frame_gate
// Expected beats come from a frame/line-level model of the gating rules.
module tb_csi2_video_frame_gate;
  localparam int DW = 16;
  localparam int CW = 13;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i;
  logic [CW-1:0] frame_width_i, frame_height_i;
  logic [DW-1:0] video_i_tdata;
  logic          video_i_tvalid, video_i_tready, video_i_tuser, video_i_tlast;
  logic [DW-1:0] video_o_tdata;
  logic          video_o_tvalid, video_o_tready, video_o_tuser, video_o_tlast;
  logic [DW/8-1:0] video_o_tkeep, video_o_tstrb;
  logic          video_o_tid, video_o_tdest;
  logic          frame_done_o, frame_err_o;
  logic [SW-1:0] frame_cnt_o, err_cnt_o;

  always #5 clk = ~clk;

  csi2_video_frame_gate #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .STAT_WIDTH(SW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable_i),
    .frame_width_i(frame_width_i), .frame_height_i(frame_height_i),
    .video_i_tdata(video_i_tdata), .video_i_tvalid(video_i_tvalid),
    .video_i_tready(video_i_tready), .video_i_tuser(video_i_tuser),
    .video_i_tlast(video_i_tlast),
    .video_o_tdata(video_o_tdata), .video_o_tvalid(video_o_tvalid),
    .video_o_tready(video_o_tready), .video_o_tuser(video_o_tuser),
    .video_o_tlast(video_o_tlast), .video_o_tkeep(video_o_tkeep),
    .video_o_tstrb(video_o_tstrb), .video_o_tid(video_o_tid),
    .video_o_tdest(video_o_tdest),
    .frame_done_o(frame_done_o), .frame_err_o(frame_err_o),
    .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    logic          dn;
  } exp_t;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            exp_frames = 0;
  int            exp_errs = 0;
  bit            open_frame = 0;
  int            done_seen = 0;
  int            err_seen = 0;
  int            ready_mode = 0;
  logic [DW-1:0] next_data = 16'h0100;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // A frame is a list of line lengths; the gate must pass lines of exactly w pixels,
  // cut the first bad line at min(n,w), and close the frame after h good lines.
  function automatic void model_frame(int w, int h, int lens[$], logic [DW-1:0] base);
    int   off = 0;
    exp_t e;
    if (open_frame) exp_errs++;
    open_frame = 1;
    for (int l = 0; l < lens.size() && l < h; l++) begin
      int n = lens[l];
      int k = (n < w) ? n : w;
      for (int i = 0; i < k; i++) begin
        e.d  = DW'(int'(base) + off + i);
        e.u  = (l == 0 && i == 0);
        e.l  = (i == k - 1);
        e.dn = (n == w && l == h - 1 && i == k - 1);
        exp_q.push_back(e);
      end
      off += n;
      if (n != w) begin
        exp_errs++;
        open_frame = 0;
        return;
      end
      if (l == h - 1) begin
        exp_frames++;
        open_frame = 0;
        return;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_beat(logic [DW-1:0] d, logic u, logic l);
    bit acc = 0;
    if ($urandom % 4 == 0) tick();
    video_i_tdata  = d;
    video_i_tuser  = u;
    video_i_tlast  = l;
    video_i_tvalid = 1'b1;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      acc = video_i_tready;
      tick();
    end
    video_i_tvalid = 1'b0;
    check("in_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_frame(int w, int h, int lens[$], bit fwd, int en_at, bit en_val, bit scramble);
    int idx = 0;
    if (fwd) model_frame(w, h, lens, next_data);
    frame_width_i  = CW'(w);
    frame_height_i = CW'(h);
    for (int l = 0; l < lens.size(); l++) begin
      for (int i = 0; i < lens[l]; i++) begin
        if (idx == en_at) enable_i = en_val;
        send_beat(DW'(int'(next_data) + idx), (l == 0 && i == 0), (i == lens[l] - 1));
        if (idx == 0 && scramble) begin
          frame_width_i  = CW'($urandom_range(1, 8));
          frame_height_i = CW'($urandom_range(1, 5));
        end
        idx++;
      end
    end
    next_data = DW'(int'(next_data) + idx + 16);
  endtask

  function automatic void mk3(output int q[$], input int a, input int b, input int c);
    q = {};
    q.push_back(a);
    q.push_back(b);
    q.push_back(c);
  endfunction

  task automatic drain(string tag);
    int t = 0;
    while ((exp_q.size() != 0 || video_o_tvalid) && t < 3000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_frame_cnt"}, frame_cnt_o, exp_frames);
    check({tag, "_err_cnt"}, err_cnt_o, exp_errs);
    check({tag, "_done_pulses"}, done_seen, exp_frames);
    check({tag, "_err_pulses"}, err_seen, exp_errs);
  endtask

  initial begin
    video_o_tready = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        0:       video_o_tready = 1'b1;
        1:       video_o_tready = ($urandom % 2 == 0);
        default: video_o_tready = 1'b0;
      endcase
    end
  end

  exp_t          e_pop;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_u, hold_l;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done_o) done_seen++;
      if (frame_err_o) err_seen++;
      if (frame_done_o && frame_err_o) check("done_err_overlap", 64'd1, 64'd0);
      if (stall_prev) begin
        check("hold_valid", {63'd0, video_o_tvalid}, 64'd1);
        check("hold_data", {48'd0, video_o_tdata}, {48'd0, hold_d});
        check("hold_sideband", {62'd0, video_o_tuser, video_o_tlast}, {62'd0, hold_u, hold_l});
      end
      if (video_o_tvalid && video_o_tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd0, 64'd1);
        end else begin
          e_pop = exp_q.pop_front();
          check("tdata", {48'd0, video_o_tdata}, {48'd0, e_pop.d});
          check("tuser", {63'd0, video_o_tuser}, {63'd0, e_pop.u});
          check("tlast", {63'd0, video_o_tlast}, {63'd0, e_pop.l});
          check("frame_done", {63'd0, frame_done_o}, {63'd0, e_pop.dn});
        end
      end
      stall_prev = video_o_tvalid && !video_o_tready;
      hold_d = video_o_tdata;
      hold_u = video_o_tuser;
      hold_l = video_o_tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int lens[$];
    rst_n          = 1'b0;
    enable_i       = 1'b1;
    frame_width_i  = 13'd4;
    frame_height_i = 13'd3;
    video_i_tdata  = '0;
    video_i_tvalid = 1'b0;
    video_i_tuser  = 1'b0;
    video_i_tlast  = 1'b0;
    #13;
    check("rst_tvalid", {63'd0, video_o_tvalid}, 64'd0);
    check("rst_tready", {63'd0, video_i_tready}, 64'd1);
    check("rst_pulses", {62'd0, frame_done_o, frame_err_o}, 64'd0);
    check("rst_cnts", {32'd0, frame_cnt_o, err_cnt_o}, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    mk3(lens, 4, 4, 4);
    send_frame(4, 3, lens, 1, -1, 0, 0);
    send_frame(4, 3, lens, 1, -1, 0, 0);
    drain("clean");

    mk3(lens, 4, 3, 4);
    send_frame(4, 3, lens, 1, -1, 0, 0);
    mk3(lens, 4, 4, 4);
    send_frame(4, 3, lens, 1, -1, 0, 0);
    drain("short_line");

    mk3(lens, 6, 4, 4);
    send_frame(4, 3, lens, 1, -1, 0, 0);
    drain("long_line");

    ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      mk3(lens, 5, 5, 5);
      send_frame(5, 3, lens, 1, -1, 0, 1);
    end
    drain("stall");

    for (int f = 0; f < 30; f++) begin
      int w  = $urandom_range(1, 6);
      int h  = $urandom_range(1, 4);
      int nl = h;
      int r  = $urandom % 10;
      if (r == 0 && h > 1) nl = h - 1;
      else if (r == 1) nl = h + 1;
      lens = {};
      for (int l = 0; l < nl; l++)
        lens.push_back(($urandom % 5 == 0) ? $urandom_range(1, w + 2) : w);
      send_frame(w, h, lens, 1, -1, 0, 1);
    end
    mk3(lens, 3, 3, 3);
    send_frame(3, 3, lens, 1, -1, 0, 0);
    drain("random");

    ready_mode = 0;
    enable_i = 1'b0;
    repeat (2) tick();
    mk3(lens, 4, 4, 4);
    send_frame(4, 3, lens, 0, 6, 1, 0);
    send_frame(4, 3, lens, 1, -1, 0, 0);
    drain("late_enable");

    send_frame(4, 3, lens, 1, 4, 0, 0);
    send_frame(4, 3, lens, 0, -1, 0, 0);
    enable_i = 1'b1;
    repeat (2) tick();
    drain("disable_mid");

    ready_mode = 2;
    repeat (2) tick();
    send_beat(16'hBEEF, 1'b1, 1'b0);
    tick();
    check("pre_rst_tvalid", {63'd0, video_o_tvalid}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", {63'd0, video_o_tvalid}, 64'd0);
    check("async_rst_frame_cnt", {48'd0, frame_cnt_o}, 64'd0);
    check("async_rst_err_cnt", {48'd0, err_cnt_o}, 64'd0);
    exp_q = {};
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
